fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter sharing the single write port of the asynchronous FIFO among NUM_REQ requesters in the write-clock domain. Grants one requester at a time for bursts of up to MAX_BURST beats, drives the FIFO's write enable and data, and honours the FIFO full flag so no beat is ever offered while the FIFO is full. Sits between the producer blocks and the FIFO's write side; also reports a saturating stall counter for debug.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATA_W, 8: data width, matches FIFO data_in
- MAX_BURST, 4: maximum accepted beats per grant (1..15)
- clk  in  1  write-side clock (same clock as the FIFO's wrclk)
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester beat valid; held until ack
- req_data  in  NUM_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
- ack  out  NUM_REQ  one-hot, beat of requester i accepted this cycle
- fifo_full  in  1  FIFO is_full
- fifo_wr_en  out  1  FIFO wr_en
- fifo_data  out  DATA_W  FIFO data_in
- owner  out  $clog2(NUM_REQ)  current grant holder (valid when busy)
- busy  out  1  FSM in GRANT
- stall_cnt  out  16  cycles owner had req high while fifo_full, saturating

## Operation
- FSM states: IDLE, GRANT.
- IDLE: if any req bit set, pick winner by round-robin starting at last_owner+1 (wrapping mod NUM_REQ); load owner, clear beat_cnt, go GRANT. No write in the arbitration cycle. No req: stay IDLE.
- GRANT, per cycle: beat = req[owner] && !fifo_full. fifo_wr_en = beat; ack[owner] = beat; fifo_data = req_data slice of owner (combinational mux, valid regardless of beat).
- On beat: beat_cnt++. If beat_cnt was MAX_BURST-1, release.
- req[owner] low: release (no beat that cycle).
- req[owner] high and fifo_full high: hold grant, no beat, beat_cnt unchanged, stall_cnt++ (saturates at 16'hFFFF).
- Release: last_owner <= owner, go IDLE. Same requester may win again only if no other requester is pending.
- Requests from non-owners are ignored (no ack) until next IDLE arbitration.
- beat_cnt width $clog2(MAX_BURST+1); never exceeds MAX_BURST-1 stored.

## Timing
- Reset (rst low, async): state IDLE, owner 0, last_owner NUM_REQ-1 (first grant favours requester 0), beat_cnt 0, stall_cnt 0, busy 0; ack, fifo_wr_en 0 (combinationally, since state is IDLE).
- Latency: req rise in IDLE -> first ack/fifo_wr_en the next cycle (1 arbitration cycle).
- Throughput: MAX_BURST beats per grant plus 1 bubble cycle per release.
- fifo_wr_en/ack are combinational from fifo_full and req; fifo_full must be the same-cycle FIFO flag; a beat is never issued while fifo_full is 1.
- Full deasserting mid-burst: beat issued the same cycle fifo_full goes low.
- Reset asserted mid-burst: grant dropped immediately; beats not acked are not written.
- stall_cnt cleared only by reset.

## Structure
- Package fifo_arb_pkg: state enum (IDLE, GRANT), localparams for owner and beat_cnt widths, stall counter width 16 and saturation value.
- One sub-module: rr_pick, combinational — inputs req vector and last_owner, outputs winner index and any_req.
- Top holds FSM, beat_cnt, last_owner, stall_cnt, data mux.

## Test plan
- Reset release, req=4'b0001, fifo_full=0, data 8'hA0..A5 -> arbitration cycle, then 4 acks (A0..A3), bubble, 2 more (A4, A5) after re-grant; owner 0 throughout.
- req=4'b1111 continuously -> grants in order 0,1,2,3,0, each exactly 4 beats, one idle cycle between grants.
- Owner 2 mid-burst, fifo_full high 3 cycles -> no fifo_wr_en for those 3 cycles, stall_cnt +3, burst completes 4 beats total after full drops.
- Owner 1 drops req after 2 beats with req[3] pending -> release, IDLE one cycle, owner 3 granted.
- fifo_full held high with owner requesting for 70000 cycles -> stall_cnt sticks at 16'hFFFF, no write ever issued.
- rst low during beat 2 of a burst -> ack/fifo_wr_en low in the same cycle, busy 0, stall_cnt 0; after release, requester 0 wins first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Default geometry of the arbiter; the top uses these as parameter defaults.
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;

  // Debug stall counter geometry.
  localparam int                 STALL_W   = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = 16'hFFFF;

  // Width of an owner index for a given requester count.
  function automatic int owner_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Width of the per-grant beat counter (holds 0..max_burst).
  function automatic int beat_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  localparam int DEF_OWNER_W = owner_w(DEF_NUM_REQ);
  localparam int DEF_BEAT_W  = beat_w(DEF_MAX_BURST);

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: first set req bit after last_owner, wrapping.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, the caller decides when to use it.
//
// Ports:
//   req        in   NUM_REQ  pending requests
//   last_owner in   OWNER_W  previous grant holder (search starts one above it)
//   winner     out  OWNER_W  selected requester (0 when no request)
//   any_req    out  1        at least one request pending
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int OWNER_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] last_owner,
  output logic [OWNER_W-1:0] winner,
  output logic               any_req
);

  // Walk the offsets from farthest to nearest so the nearest pending
  // requester after last_owner is the final assignment and wins.
  always_comb begin
    winner = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req[j] && (((int'(last_owner) + off) % NUM_REQ) == j)) begin
          winner = OWNER_W'(j);
        end
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Latency: one arbitration cycle from req to first ack; then one beat per cycle.
// Backpressure: fifo_full gates beats combinationally; owner keeps the grant while stalled.
//
// Ports:
//   clk, rst     write-side clock, asynchronous active-low reset
//   req/req_data per-requester beat valid (held until ack) and data slices
//   ack          one-hot beat acceptance
//   fifo_full    same-cycle FIFO full flag
//   fifo_wr_en/fifo_data  FIFO write strobe and data
//   owner/busy   current grant holder and grant-active flag
//   stall_cnt    saturating count of cycles the owner was blocked by full
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int OWNER_W   = owner_w(NUM_REQ),
  localparam int BEAT_W    = beat_w(MAX_BURST)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data,
  output logic [OWNER_W-1:0]        owner,
  output logic                      busy,
  output logic [STALL_W-1:0]        stall_cnt
);

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(MAX_BURST - 1);
  localparam logic [OWNER_W-1:0] INIT_OWNER = OWNER_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   last_owner_q, last_owner_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic [OWNER_W-1:0]   winner;
  logic                 any_req;
  logic                 owner_req;
  logic [NUM_REQ-1:0]   owner_hot;
  logic                 beat;
  logic                 rel_grant;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWNER_W (OWNER_W)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  // Owner-selected request bit, one-hot owner and data slice. The data mux
  // is driven whether or not a beat happens.
  always_comb begin
    owner_req = 1'b0;
    owner_hot = '0;
    fifo_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (owner_q == OWNER_W'(j)) begin
        owner_req    = req[j];
        owner_hot[j] = 1'b1;
        fifo_data    = req_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    beat         = 1'b0;
    rel_grant    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Arbitration cycle: no write is issued here.
        if (any_req) begin
          owner_d    = winner;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          rel_grant = 1'b1;
        end else if (fifo_full) begin
          // Hold the grant; count the blocked cycle.
          if (stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
          end
        end else begin
          beat = 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            rel_grant = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
        if (rel_grant) begin
          last_owner_d = owner_q;
          beat_cnt_d   = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= INIT_OWNER;
      beat_cnt_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign fifo_wr_en = beat;
  assign ack        = beat ? owner_hot : '0;
  assign owner      = owner_q;
  assign busy       = (state_q == GRANT);
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed producers, expected writes queued up front.
// Latency: writes are checked against an expected cycle stamp relative to reset release.
// Backpressure: fifo_full is driven directly by the directed sequences.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    ack;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_data;
  logic [1:0]       owner;
  logic             busy;
  logic [15:0]      stall_cnt;

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .MAX_BURST (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .owner      (owner),
    .busy       (busy),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         stamp;
    int         own;
    logic [7:0] dat;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc_n   = 0;
  int         t0      = 0;
  int         rel;
  logic [NR-1:0] ack_s;

  // Producer model: per-requester list of beats, head advanced on ack.
  logic [7:0] pdat [NR][16];
  int         phead [NR];
  int         ptail [NR];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Monitor: every accepted beat must match the next expected write.
  always @(negedge clk) begin
    ack_s = ack;
    if (rst && (fifo_wr_en || ack != '0)) begin
      rel = cyc_n - t0;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: cycle %0d owner %0d data %02h ack %b, expected no write",
                 rel, owner, fifo_data, ack);
      end else begin
        e = sb.pop_front();
        if (!(rel == e.stamp && int'(owner) == e.own && fifo_data == e.dat &&
              ack == (4'b0001 << e.own) && fifo_wr_en && !fifo_full)) begin
          n_fail++;
          $display("FAIL write: got cycle %0d owner %0d data %02h ack %b wr_en %b full %b, expected cycle %0d owner %0d data %02h",
                   rel, owner, fifo_data, ack, fifo_wr_en, fifo_full, e.stamp, e.own, e.dat);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input int stamp, input int own, input logic [7:0] dat);
    exp_t x;
    x.stamp = stamp;
    x.own   = own;
    x.dat   = dat;
    sb.push_back(x);
  endtask

  task automatic load(input int r, input int n, input logic [7:0] base);
    for (int j = 0; j < n; j++) pdat[r][j] = base + 8'(j);
    phead[r] = 0;
    ptail[r] = n;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req[i] = (phead[i] < ptail[i]);
      req_data[i*DW +: DW] = req[i] ? pdat[i][phead[i]] : 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (ack_s[i]) phead[i]++;
    drive();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic reset_on();
    rst       = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
    end
    drive();
  endtask

  task automatic reset_off();
    tick();
    tick();
    rst = 1'b1;
    t0  = cyc_n;
  endtask

  initial begin
    int st1[6];
    rst       = 1'b0;
    fifo_full = 1'b0;
    req       = '0;
    req_data  = '0;

    // T1: single requester, 6 beats -> burst of 4, bubble, burst of 2.
    reset_on();
    load(0, 6, 8'hA0);
    drive();
    settle();
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_en", int'(fifo_wr_en), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_stall", int'(stall_cnt), 0);
    reset_off();
    st1 = '{1, 2, 3, 4, 6, 7};
    for (int k = 0; k < 6; k++) push(st1[k], 0, 8'(8'hA0 + k));
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) begin settle(); chk("t1_owner", int'(owner), 0); end
      if (k == 5) begin settle(); chk("t1_bubble_busy", int'(busy), 0); end
    end
    chk("t1_drain", sb.size(), 0);

    // T2: all four requesting -> grants 0,1,2,3,0,1,2,3 of 4 beats with one idle cycle between.
    reset_on();
    for (int i = 0; i < NR; i++) load(i, 8, 8'(128 + 16 * i));
    reset_off();
    for (int g = 0; g < 8; g++)
      for (int b = 0; b < 4; b++)
        push(g * 5 + 1 + b, g % 4, 8'(128 + 16 * (g % 4) + (g / 4) * 4 + b));
    for (int k = 1; k <= 45; k++) tick();
    chk("t2_drain", sb.size(), 0);
    chk("t2_idle", int'(busy), 0);

    // T3: owner 2 stalled by full for 3 cycles mid-burst.
    reset_on();
    load(2, 4, 8'hC0);
    reset_off();
    push(1, 2, 8'hC0);
    push(2, 2, 8'hC1);
    push(6, 2, 8'hC2);
    push(7, 2, 8'hC3);
    for (int k = 1; k <= 10; k++) begin
      tick();
      fifo_full = (k >= 3 && k <= 5);
      if (k == 4) begin
        settle();
        chk("t3_stall_busy", int'(busy), 1);
        chk("t3_stall_owner", int'(owner), 2);
        chk("t3_stall_wr_en", int'(fifo_wr_en), 0);
      end
    end
    chk("t3_stall_cnt", int'(stall_cnt), 3);
    chk("t3_drain", sb.size(), 0);

    // T4: owner 1 drops req after 2 beats, requester 3 pending.
    reset_on();
    load(1, 2, 8'hB0);
    load(3, 2, 8'hD0);
    reset_off();
    push(1, 1, 8'hB0);
    push(2, 1, 8'hB1);
    push(5, 3, 8'hD0);
    push(6, 3, 8'hD1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) begin
        settle();
        chk("t4_release_busy", int'(busy), 1);
        chk("t4_release_wr_en", int'(fifo_wr_en), 0);
      end
      if (k == 4) begin settle(); chk("t4_idle_busy", int'(busy), 0); end
      if (k == 5) begin settle(); chk("t4_new_owner", int'(owner), 3); end
    end
    chk("t4_drain", sb.size(), 0);

    // T5: full held long enough to saturate the stall counter; no write meanwhile.
    reset_on();
    load(0, 1, 8'h77);
    fifo_full = 1'b1;
    reset_off();
    for (int k = 1; k <= 65600; k++) begin
      tick();
      if (k == 1001) begin settle(); chk("t5_stall_1000", int'(stall_cnt), 1000); end
    end
    chk("t5_stall_sat", int'(stall_cnt), 16'hFFFF);
    push(65600, 0, 8'h77);
    fifo_full = 1'b0;
    tick();
    tick();
    settle();
    chk("t5_stall_held", int'(stall_cnt), 16'hFFFF);
    chk("t5_drain", sb.size(), 0);

    // T6: reset asserted during beat 2 of a burst.
    reset_on();
    load(1, 4, 8'hF0);
    reset_off();
    push(1, 1, 8'hF0);
    tick();
    tick();
    fifo_full = 1'b1;
    tick();
    tick();
    fifo_full = 1'b0;
    settle();
    chk("t6_beat2_wr_en", int'(fifo_wr_en), 1);
    chk("t6_pre_stall", int'(stall_cnt), 2);
    rst = 1'b0;
    #1;
    chk("t6_rst_ack", int'(ack), 0);
    chk("t6_rst_wr_en", int'(fifo_wr_en), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_stall", int'(stall_cnt), 0);
    load(0, 1, 8'h5A);
    drive();
    reset_off();
    push(1, 0, 8'h5A);
    push(4, 1, 8'hF1);
    push(5, 1, 8'hF2);
    push(6, 1, 8'hF3);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin settle(); chk("t6_first_owner", int'(owner), 0); end
    end
    chk("t6_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
